// File: rtl/riscv_pkg.sv
// Datapath-wide widths and ALU opcode encodings shared by the fetch stage and ALU blocks.
// The read_val helper gives the operand value as seen through the same-cycle write-back bypass.
package riscv_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 4;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_XOR = 4'h3,
    ALU_OR  = 4'h4,
    ALU_SLL = 4'h5,
    ALU_SRL = 4'h6,
    ALU_SRA = 4'h7
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } fetch_state_e;

  function automatic logic [DATA_W-1:0] read_val(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] rf_val,
    input logic              wb_en,
    input logic [ADDR_W-1:0] wb_addr,
    input logic [DATA_W-1:0] wb_data
  );
    if (addr == '0)
      return '0;
    else if (wb_en && (wb_addr == addr))
      return wb_data;
    else
      return rf_val;
  endfunction
endpackage

// File: rtl/opfetch32_if.sv
// Issue handshake, write-back port and ALU-side operand handshake of the operand-fetch stage.
// The slave modport is the stage itself; master is whatever drives it (issue/ALU/bench).
interface opfetch32_if;
  import riscv_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rs1;
  logic [ADDR_W-1:0] in_rs2;
  logic [ADDR_W-1:0] in_rd;
  logic [OP_W-1:0]   in_op;
  logic              flush;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [OP_W-1:0]   op_out;
  logic [ADDR_W-1:0] rd_out;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_op, flush,
    input  wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, a, b, op_out, rd_out
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_op, flush,
    output wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, a, b, op_out, rd_out
  );
endinterface

// File: rtl/regfile32.sv
// 2-read / 1-write register file, combinational reads, r0 hard-wired to zero.
// Async active-low reset clears every entry.
module regfile32
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);
  logic [DATA_W-1:0] mem_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];
endmodule

// File: rtl/opfetch32.sv
// Operand-fetch stage: state | meaning -- EMPTY | nothing presented to ALU; FULL | a/b/op/rd valid.
// A stalled entry is refreshed by matching write-backs so it never goes stale while held.
module opfetch32
  import riscv_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  opfetch32_if.slave  bus
);
  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic              in_ready, accept, wb_live;

  regfile32 u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (bus.wb_en),
    .waddr_i  (bus.wb_addr),
    .wdata_i  (bus.wb_data),
    .raddr1_i (bus.in_rs1),
    .raddr2_i (bus.in_rs2),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2)
  );

  assign in_ready = (state_q == ST_EMPTY) || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign wb_live  = bus.wb_en && (bus.wb_addr != '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d = ST_FULL;
      a_d     = read_val(bus.in_rs1, rf_rd1, bus.wb_en, bus.wb_addr, bus.wb_data);
      b_d     = read_val(bus.in_rs2, rf_rd2, bus.wb_en, bus.wb_addr, bus.wb_data);
      op_d    = bus.in_op;
      rd_d    = bus.in_rd;
      rs1_d   = bus.in_rs1;
      rs2_d   = bus.in_rs2;
    end else if ((state_q == ST_FULL) && bus.out_ready) begin
      state_d = ST_EMPTY;
    end else if (state_q == ST_FULL) begin
      // stalled: keep held operands coherent with later write-backs
      if (wb_live && (bus.wb_addr == rs1_q)) a_d = bus.wb_data;
      if (wb_live && (bus.wb_addr == rs2_q)) b_d = bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.op_out    = op_q;
  assign bus.rd_out    = rd_q;
endmodule

// File: tb/tb_opfetch32.sv
// Bench for opfetch32: spec-level model checked every cycle, plus literal expectations per scenario.
module tb_opfetch32;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic chk_en;

  opfetch32_if bus ();

  opfetch32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state: architectural register file plus the one entry the stage presents
  logic [31:0] mrf [32];
  logic        m_valid;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic [63:0] consumed [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
      if (m_valid) begin
        chk("a", bus.a, m_a);
        chk("b", bus.b, m_b);
        chk("op_out", 32'(bus.op_out), 32'(m_op));
        chk("rd_out", 32'(bus.rd_out), 32'(m_rd));
      end
    end
  end

  function automatic logic [31:0] rdv(input logic [4:0] x);
    if (x == 5'd0) return 32'h0;
    if (bus.wb_en && bus.wb_addr == x) return bus.wb_data;
    return mrf[x];
  endfunction

  task automatic cycle();
    logic        nv;
    logic [31:0] na, nb;
    logic [3:0]  nop;
    logic [4:0]  nrd, nrs1, nrs2;
    logic        rdy;
    nv = m_valid; na = m_a; nb = m_b; nop = m_op; nrd = m_rd; nrs1 = m_rs1; nrs2 = m_rs2;
    rdy = !m_valid || bus.out_ready;
    if (bus.flush) begin
      nv = 1'b0;
    end else if (bus.in_valid && rdy) begin
      nv = 1'b1;
      na = rdv(bus.in_rs1);
      nb = rdv(bus.in_rs2);
      nop = bus.in_op; nrd = bus.in_rd; nrs1 = bus.in_rs1; nrs2 = bus.in_rs2;
    end else if (m_valid && bus.out_ready) begin
      nv = 1'b0;
    end else if (m_valid && bus.wb_en && bus.wb_addr != 5'd0) begin
      if (bus.wb_addr == m_rs1) na = bus.wb_data;
      if (bus.wb_addr == m_rs2) nb = bus.wb_data;
    end
    if (bus.out_valid && bus.out_ready && !bus.flush) consumed.push_back({bus.a, bus.b});
    @(posedge clk);
    #1;
    if (bus.wb_en && bus.wb_addr != 5'd0) mrf[bus.wb_addr] = bus.wb_data;
    m_valid = nv; m_a = na; m_b = nb; m_op = nop; m_rd = nrd; m_rs1 = nrs1; m_rs2 = nrs2;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.wb_en = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [3:0] op,
                       input logic [4:0] rd);
    bus.in_valid = 1'b1; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_op = op; bus.in_rd = rd;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    bus.wb_en = 1'b1; bus.wb_addr = addr; bus.wb_data = data;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_valid = 1'b0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_a", bus.a, 32'h0);
    chk("rst_b", bus.b, 32'h0);
    chk("rst_op", 32'(bus.op_out), 32'h0);
    chk("rst_rd", 32'(bus.rd_out), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int i, cyc;
    logic acc;
    n_cmp = 0; n_err = 0; chk_en = 1'b0;
    rst_n = 1'b0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_op = '0; bus.in_rd = '0;
    bus.wb_addr = '0; bus.wb_data = '0;
    idle();
    do_reset();
    chk_en = 1'b1;

    // reset state read back through the register file
    issue(5'd5, 5'd6, 4'h1, 5'd1); cycle(); bus.in_valid = 1'b0;
    chk("rst_read_a", bus.a, 32'h0);
    chk("rst_read_b", bus.b, 32'h0);
    cycle();

    // write-then-read
    wb(5'd5, 32'hFFDF1F40); cycle();
    wb(5'd6, 32'h80031F4F); cycle();
    bus.wb_en = 1'b0;
    issue(5'd5, 5'd6, 4'h3, 5'd7); cycle(); bus.in_valid = 1'b0;
    chk("wr_valid", 32'(bus.out_valid), 32'h1);
    chk("wr_a", bus.a, 32'hFFDF1F40);
    chk("wr_b", bus.b, 32'h80031F4F);
    chk("wr_op", 32'(bus.op_out), 32'h3);
    chk("wr_rd", 32'(bus.rd_out), 32'h7);
    cycle();

    // r0 stays zero, including when written in the accept cycle
    wb(5'd0, 32'hFFFFFFFF); cycle();
    issue(5'd0, 5'd5, 4'h2, 5'd2); cycle(); bus.in_valid = 1'b0; bus.wb_en = 1'b0;
    chk("r0_a", bus.a, 32'h0);
    chk("r0_b", bus.b, 32'hFFDF1F40);
    cycle();

    // same-cycle bypass, then the same value through the register file
    issue(5'd9, 5'd0, 4'h4, 5'd3); wb(5'd9, 32'h23489ABC); cycle();
    bus.wb_en = 1'b0;
    chk("byp_a", bus.a, 32'h23489ABC);
    issue(5'd9, 5'd9, 4'h4, 5'd3); cycle(); bus.in_valid = 1'b0;
    chk("rf_a", bus.a, 32'h23489ABC);
    chk("rf_b", bus.b, 32'h23489ABC);
    cycle();

    // stall refresh
    wb(5'd3, 32'h00000001); cycle(); bus.wb_en = 1'b0;
    issue(5'd2, 5'd3, 4'h5, 5'd8); cycle();
    issue(5'd11, 5'd12, 4'h6, 5'd9); bus.out_ready = 1'b0;
    chk("st_b0", bus.b, 32'h00000001);
    wb(5'd3, 32'h12AFE847); cycle();
    chk("st_b1", bus.b, 32'h12AFE847);
    chk("st_ready", 32'(bus.in_ready), 32'h0);
    wb(5'd4, 32'h00000055); cycle();
    chk("st_r4_a", bus.a, 32'h0);
    chk("st_r4_b", bus.b, 32'h12AFE847);
    chk("st_r4_op", 32'(bus.op_out), 32'h5);
    idle(); cycle(); cycle();

    // back-to-back with toggling backpressure
    for (int k = 10; k < 20; k++) begin
      wb(5'(k), 32'hA5000000 | 32'(k)); cycle();
    end
    bus.wb_en = 1'b0;
    consumed.delete();
    i = 0; cyc = 0;
    while (i < 10 && cyc < 100) begin
      issue(5'(10 + i), 5'(19 - i), 4'(i), 5'(i));
      bus.out_ready = cyc[0] ? 1'b0 : 1'b1;
      acc = !m_valid || bus.out_ready;
      cycle();
      if (acc) i++;
      cyc++;
    end
    chk("b2b_accepts", 32'(i), 32'd10);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    chk("b2b_count", 32'(consumed.size()), 32'd10);
    for (int j = 0; j < 10 && j < consumed.size(); j++) begin
      chk("b2b_a", consumed[j][63:32], 32'hA5000000 | 32'(10 + j));
      chk("b2b_b", consumed[j][31:0], 32'hA5000000 | 32'(19 - j));
    end

    // flush from EMPTY discards a same-cycle accept
    issue(5'd5, 5'd6, 4'hE, 5'd30); bus.flush = 1'b1; cycle();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("fl0_valid", 32'(bus.out_valid), 32'h0);
    cycle();

    // flush while FULL and stalled, write-back still lands
    bus.out_ready = 1'b0;
    issue(5'd5, 5'd6, 4'h1, 5'd1); cycle();
    issue(5'd9, 5'd9, 4'hF, 5'd31); bus.flush = 1'b1; wb(5'd7, 32'h00000077); cycle();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.wb_en = 1'b0;
    chk("fl1_valid", 32'(bus.out_valid), 32'h0);
    cycle(); bus.out_ready = 1'b1; cycle(); cycle();
    chk("fl1_gone", 32'(bus.out_valid), 32'h0);
    issue(5'd7, 5'd0, 4'h2, 5'd2); cycle(); bus.in_valid = 1'b0;
    chk("fl1_wb", bus.a, 32'h00000077);
    cycle();

    // reset mid-stream drops the held entry and clears the register file
    bus.out_ready = 1'b0;
    issue(5'd5, 5'd6, 4'h3, 5'd4); cycle(); bus.in_valid = 1'b0;
    chk("mr_full", 32'(bus.out_valid), 32'h1);
    do_reset();
    bus.out_ready = 1'b1;
    issue(5'd5, 5'd6, 4'h3, 5'd4); cycle(); bus.in_valid = 1'b0;
    chk("mr_a", bus.a, 32'h0);
    chk("mr_b", bus.b, 32'h0);
    cycle(); cycle();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
